// File: rtl/pipereg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipereg_pkg
// Description : Shared defaults and helpers for the MEM->WB pipeline register.
// Revision    : 1.0  initial release
// ============================================================================
package pipereg_pkg;

    localparam int c_data_w = 32;
    localparam int c_wa_w   = 4;
    localparam int c_stat_w = 16;

    // Bit offset of a lane inside a packed multi-lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipereg_wb_n_if.sv
`default_nettype none
// ============================================================================
// Interface   : pipereg_wb_n_if
// Description : Input/output entry bus plus stall/flush controls of pipereg_wb_n.
// Revision    : 1.0  initial release
// ============================================================================
interface pipereg_wb_n_if
    import pipereg_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int LANES  = 2,
    parameter int WA_W   = c_wa_w
);
    logic                      stall;
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_data;
    logic [WA_W-1:0]           in_wa;
    logic                      in_regwr;
    logic                      out_valid;
    logic [LANES*DATA_W-1:0]   out_data;
    logic [WA_W-1:0]           out_wa;
    logic                      out_regwr;

    modport master (
        output stall, flush, in_valid, in_data, in_wa, in_regwr,
        input  in_ready, out_valid, out_data, out_wa, out_regwr
    );

    modport slave (
        input  stall, flush, in_valid, in_data, in_wa, in_regwr,
        output in_ready, out_valid, out_data, out_wa, out_regwr
    );
endinterface
`default_nettype wire

// File: rtl/pipereg_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipereg_slot
// Description : One pipeline stage: valid bit plus payload, loads its source on i_ld.
// Revision    : 1.0  initial release
// ============================================================================
module pipereg_slot #(
    parameter int PAY_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_ld,
    input  logic             i_flush,
    input  logic             i_src_valid,
    input  logic [PAY_W-1:0] i_src_pay,
    output logic             o_valid,
    output logic [PAY_W-1:0] o_pay
);
    logic             valid_q, valid_d;
    logic [PAY_W-1:0] pay_q, pay_d;

    // Payload moves only with a valid source, so empty slots keep stale data.
    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_ld) begin
            valid_d = i_src_valid;
            if (i_src_valid) begin
                pay_d = i_src_pay;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign o_valid = valid_q;
    assign o_pay   = pay_q;
endmodule
`default_nettype wire

// File: rtl/pipereg_wb_n.sv
`default_nettype none
// ============================================================================
// Module      : pipereg_wb_n
// Description : DEPTH-stage MEM->WB register with stall, flush, bubble collapsing.
//               Build option PIPEREG_WB_STATS_EN adds stall/bubble counters.
// Revision    : 1.0  initial release
// ============================================================================
module pipereg_wb_n
    import pipereg_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int LANES  = 2,
    parameter int WA_W   = c_wa_w,
    parameter int DEPTH  = 1
) (
    input  logic                clk,
    input  logic                reset,
    pipereg_wb_n_if.slave       bus
`ifdef PIPEREG_WB_STATS_EN
    ,
    output logic [c_stat_w-1:0] stat_stall,
    output logic [c_stat_w-1:0] stat_bubble
`endif
);
    localparam int c_dat_w = LANES * DATA_W;
    localparam int c_pay_w = c_dat_w + WA_W + 1;

    logic [DEPTH-1:0]   w_valid;
    logic [DEPTH-1:0]   w_ld;
    logic [c_pay_w-1:0] w_pay [DEPTH];
    logic [c_pay_w-1:0] w_in_pay;
    logic [c_pay_w-1:0] w_out_pay;

    assign w_in_pay = {bus.in_regwr, bus.in_wa, bus.in_data};

    // A stage may load when the stage ahead moves on or when it is itself empty.
    always_comb begin
        w_ld = '0;
        w_ld[DEPTH-1] = !bus.stall || !w_valid[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_ld[i] = w_ld[i+1] || !w_valid[i];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic               w_src_valid;
        logic [c_pay_w-1:0] w_src_pay;

        if (g == 0) begin : g_head
            assign w_src_valid = bus.in_valid;
            assign w_src_pay   = w_in_pay;
        end else begin : g_body
            assign w_src_valid = w_valid[g-1];
            assign w_src_pay   = w_pay[g-1];
        end

        pipereg_slot #(
            .PAY_W (c_pay_w)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .i_ld        (w_ld[g]),
            .i_flush     (bus.flush),
            .i_src_valid (w_src_valid),
            .i_src_pay   (w_src_pay),
            .o_valid     (w_valid[g]),
            .o_pay       (w_pay[g])
        );
    end

    assign w_out_pay     = w_pay[DEPTH-1];
    assign bus.in_ready  = w_ld[0] && !bus.flush && reset;
    assign bus.out_valid = w_valid[DEPTH-1];
    assign bus.out_data  = w_out_pay[c_dat_w-1:0];
    assign bus.out_wa    = w_out_pay[c_dat_w +: WA_W];
    assign bus.out_regwr = w_valid[DEPTH-1] && w_out_pay[c_pay_w-1];

`ifdef PIPEREG_WB_STATS_EN
    logic [c_stat_w-1:0] stall_cnt_q, stall_cnt_d;
    logic [c_stat_w-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; flush deliberately leaves them alone.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (w_valid[DEPTH-1] && bus.stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!w_valid[DEPTH-1] && !bus.stall && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stat_stall  = stall_cnt_q;
    assign stat_bubble = bubble_cnt_q;
`endif
endmodule
`default_nettype wire
